zuss_lsu: RTL and testbench

Load/store unit that sits directly upstream of the ZUSS data memory (1024 words × 4 byte lanes, per-lane write enables, synchronous read with one-cycle latency). It accepts byte, halfword and word requests from the pipeline, drives word-aligned addresses, lane write enables and lane-aligned store data into the memory, and returns aligned, sign- or zero-extended load data. Accesses that cross a word boundary are split into two memory accesses.

---
 rtl/zuss_lsu_if.sv | 27 ++
 rtl/zuss_lsu.sv | 156 +++++++++++++++
 tb/tb_zuss_lsu.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/zuss_lsu_if.sv
// zuss_lsu_if: pipeline request/response channel plus the data-memory port of the ZUSS load/store unit.
// The slave modport is the LSU itself; the master modport is its environment (pipeline and memory).
interface zuss_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/zuss_lsu.sv
// zuss_lsu: byte/half/word load-store unit in front of the ZUSS data memory.
// Misaligned accesses that straddle a word boundary become two memory accesses.
//
// state | meaning
// IDLE  | ready for a request; response (if any) is presented here
// A0    | first (or only) memory word addressed / written
// A1    | second word of a split access; first read word captured
// FIN   | last read word on mem_rdata; response composed at exit
module zuss_lsu (
    input  logic      clk,
    input  logic      rst,
    zuss_lsu_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_A0   = 2'd1,
        S_A1   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_accept;
    logic [3:0]  w_req_nmask;
    logic [7:0]  w_req_lanes;
    logic [63:0] w_req_data;
    logic        w_req_split;

    logic        r_we;
    logic        r_unsigned;
    logic        r_split;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic [3:0]  r_hi_we;
    logic [31:0] r_hi_wdata;
    logic [31:0] r_lo_buf;

    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_we;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;

    logic [63:0] w_load_w64;
    logic [31:0] w_load_x;
    logic [31:0] w_load;

    assign w_accept       = bus.req_valid && (r_state == S_IDLE);
    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_we     = r_mem_we;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.req_valid) w_state_nxt = S_A0;
            S_A0:    w_state_nxt = r_split ? S_A1 : S_FIN;
            S_A1:    w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request decode: lanes and shifted data across an 8-lane (two-word) window.
    always_comb begin
        case (bus.req_size)
            2'b00:   w_req_nmask = 4'b0001;
            2'b01:   w_req_nmask = 4'b0011;
            default: w_req_nmask = 4'b1111;
        endcase
        w_req_lanes = {4'b0000, w_req_nmask} << bus.req_addr[1:0];
        w_req_split = |w_req_lanes[7:4];
        w_req_data  = {32'h0000_0000, bus.req_wdata} << {bus.req_addr[1:0], 3'b000};
    end

    // Load compose: align the one or two read words and extend to 32 bits.
    always_comb begin
        w_load_w64 = r_split ? {bus.mem_rdata, r_lo_buf} : {32'h0000_0000, bus.mem_rdata};
        w_load_x   = w_load_w64[{r_off, 3'b000} +: 32];
        case (r_size)
            2'b00:   w_load = {{24{~r_unsigned & w_load_x[7]}}, w_load_x[7:0]};
            2'b01:   w_load = {{16{~r_unsigned & w_load_x[15]}}, w_load_x[15:0]};
            default: w_load = w_load_x;
        endcase
    end

    // Datapath: request capture, registered memory port, read buffering and response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_unsigned   <= 1'b0;
            r_split      <= 1'b0;
            r_size       <= 2'b00;
            r_off        <= 2'b00;
            r_hi_we      <= 4'b0000;
            r_hi_wdata   <= 32'h0000_0000;
            r_lo_buf     <= 32'h0000_0000;
            r_mem_addr   <= 32'h0000_0000;
            r_mem_wdata  <= 32'h0000_0000;
            r_mem_we     <= 4'b0000;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we        <= bus.req_we;
                        r_unsigned  <= bus.req_unsigned;
                        r_split     <= w_req_split;
                        r_size      <= bus.req_size;
                        r_off       <= bus.req_addr[1:0];
                        // Second-word lanes/data are precomputed so A1 needs no shifter.
                        r_hi_we     <= bus.req_we ? w_req_lanes[7:4] : 4'b0000;
                        r_hi_wdata  <= w_req_data[63:32];
                        r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
                        r_mem_we    <= bus.req_we ? w_req_lanes[3:0] : 4'b0000;
                        r_mem_wdata <= w_req_data[31:0];
                    end
                end
                S_A0: begin
                    if (r_split) begin
                        r_mem_addr  <= r_mem_addr + 32'd4;
                        r_mem_we    <= r_hi_we;
                        r_mem_wdata <= r_hi_wdata;
                    end else begin
                        r_mem_we    <= 4'b0000;
                    end
                end
                S_A1: begin
                    r_lo_buf <= bus.mem_rdata;
                    r_mem_we <= 4'b0000;
                end
                S_FIN: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= r_we ? 32'h0000_0000 : w_load;
                end
                default: r_mem_we <= 4'b0000;
            endcase
        end
    end
endmodule

// File: tb/tb_zuss_lsu.sv
// tb_zuss_lsu: directed plan cases plus randomized traffic against a byte-addressed reference memory.
module tb_zuss_lsu;
    logic clk;
    logic rst;
    logic mem_init;

    int n_checks;
    int n_errors;
    logic [31:0] last_rdata;

    logic [31:0] mem_words [0:1023];
    logic [7:0]  ref_mem   [0:4095];

    zuss_lsu_if bus ();

    zuss_lsu u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: per-lane writes, one-cycle synchronous read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int w = 0; w < 1024; w++) mem_words[w] <= 32'h0;
            bus.mem_rdata <= 32'h0;
        end else begin
            for (int l = 0; l < 4; l++)
                if (bus.mem_we[l]) mem_words[bus.mem_addr[11:2]][8*l +: 8] <= bus.mem_wdata[8*l +: 8];
            bus.mem_rdata <= mem_words[bus.mem_addr[11:2]];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        logic [31:0] v;
        logic [31:0] a;
        int n;
        n = nbytes(size);
        v = '0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            v[8*i +: 8] = ref_mem[a[11:0]];
        end
        if (!uns && v[8*n-1])
            for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] a;
        for (int i = 0; i < nbytes(size); i++) begin
            a = addr + 32'(i);
            ref_mem[a[11:0]] = wdata[8*i +: 8];
        end
    endtask

    // One access, starting between edges in IDLE; returns in the response cycle.
    task automatic xfer(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic hold);
        int n;
        int off;
        int pos;
        logic split;
        logic [3:0] we0, we1;
        logic [31:0] wd0, wd1, m0, m1, exp_rd, a0, a1;
        n = nbytes(size);
        off = int'(addr[1:0]);
        split = (off + n) > 4;
        we0 = '0; we1 = '0; wd0 = '0; wd1 = '0; m0 = '0; m1 = '0;
        for (int i = 0; i < n; i++) begin
            pos = off + i;
            if (pos < 4) begin
                we0[pos] = 1'b1;
                wd0[8*pos +: 8] = wdata[8*i +: 8];
                m0[8*pos +: 8] = 8'hFF;
            end else begin
                we1[pos-4] = 1'b1;
                wd1[8*(pos-4) +: 8] = wdata[8*i +: 8];
                m1[8*(pos-4) +: 8] = 8'hFF;
            end
        end
        a0 = {addr[31:2], 2'b00};
        a1 = a0 + 32'd4;
        exp_rd = we ? 32'h0 : ref_load(addr, size, uns);

        check_val("idle_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;

        @(posedge clk); #1;
        if (!hold) bus.req_valid = 1'b0;
        check_val("a0_ready", 32'(bus.req_ready), 32'd0);
        check_val("a0_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_val("a0_addr", bus.mem_addr, a0);
        check_val("a0_we", 32'(bus.mem_we), we ? 32'(we0) : 32'd0);
        if (we) check_val("a0_wdata", bus.mem_wdata & m0, wd0);

        if (split) begin
            @(posedge clk); #1;
            check_val("a1_ready", 32'(bus.req_ready), 32'd0);
            check_val("a1_addr", bus.mem_addr, a1);
            check_val("a1_we", 32'(bus.mem_we), we ? 32'(we1) : 32'd0);
            if (we) check_val("a1_wdata", bus.mem_wdata & m1, wd1);
        end

        @(posedge clk); #1;
        check_val("fin_ready", 32'(bus.req_ready), 32'd0);
        check_val("fin_we", 32'(bus.mem_we), 32'd0);
        check_val("fin_addr", bus.mem_addr, split ? a1 : a0);
        check_val("fin_resp_valid", 32'(bus.resp_valid), 32'd0);

        @(posedge clk); #1;
        check_val("resp_valid", 32'(bus.resp_valid), 32'd1);
        check_val("resp_rdata", bus.resp_rdata, exp_rd);
        check_val("resp_ready", 32'(bus.req_ready), 32'd1);
        last_rdata = bus.resp_rdata;
        if (we) ref_store(addr, size, wdata);
    endtask

    initial begin
        int pulses;
        logic we, uns, hold;
        logic [1:0] size;
        logic [31:0] addr;

        n_checks = 0;
        n_errors = 0;
        last_rdata = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        mem_init = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("rst_ready", 32'(bus.req_ready), 32'd1);
        check_val("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_val("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check_val("rst_mem_addr", bus.mem_addr, 32'd0);
        check_val("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check_val("rst_mem_we", 32'(bus.mem_we), 32'd0);

        xfer(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0);
        xfer(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0);
        check_val("plan_word_load", last_rdata, 32'hDEADBEEF);
        xfer(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b0);
        check_val("plan_byte_signed", last_rdata, 32'hFFFFFFDE);
        xfer(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b0);
        check_val("plan_byte_unsigned", last_rdata, 32'h000000DE);
        xfer(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000005A, 1'b0);
        xfer(1'b1, 2'b01, 1'b0, 32'h203, 32'h0000A1B2, 1'b0);
        xfer(1'b0, 2'b01, 1'b0, 32'h203, 32'h0, 1'b0);
        check_val("plan_split_half", last_rdata, 32'hFFFFA1B2);
        xfer(1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h11223344, 1'b0);
        xfer(1'b0, 2'b11, 1'b0, 32'hFFFFFFFE, 32'h0, 1'b0);
        check_val("plan_wrap_word", last_rdata, 32'h11223344);

        // Back-to-back with req_valid held high throughout.
        xfer(1'b1, 2'b00, 1'b0, 32'h040, 32'h000000C3, 1'b1);
        xfer(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);
        xfer(1'b0, 2'b01, 1'b1, 32'h03F, 32'h0, 1'b0);

        // Reset during A1 of a split store: only the A0 lanes may be written.
        bus.req_we = 1'b1;
        bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h302;
        bus.req_wdata = 32'hCAFEF00D;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check_val("rstop_a0_we", 32'(bus.mem_we), 32'hC);
        @(posedge clk); #1;
        check_val("rstop_a1_we", 32'(bus.mem_we), 32'h3);
        #2 rst = 1'b1;
        #1;
        check_val("rstop_we_clear", 32'(bus.mem_we), 32'd0);
        check_val("rstop_addr_clear", bus.mem_addr, 32'd0);
        check_val("rstop_resp_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rstop_ready", 32'(bus.req_ready), 32'd1);
        pulses = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.resp_valid) pulses++;
        end
        check_val("rstop_no_resp", 32'(pulses), 32'd0);
        ref_mem[12'h302] = 8'h0D;
        ref_mem[12'h303] = 8'hF0;
        xfer(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0);
        xfer(1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 1'b0);

        // Randomized traffic over a small window plus the top-of-address-space wrap.
        for (int k = 0; k < 300; k++) begin
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            else addr = 32'h380 + 32'($urandom_range(0, 63));
            xfer(we, size, uns, addr, $urandom, hold);
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
